// File: rtl/multiplier_seq.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiplier_seq #(
    parameter int BITSIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strt,
    input  logic [BITSIZE-1:0]     multiplicand,
    input  logic [BITSIZE-1:0]     multiplier,
    input  logic [BITSIZE-1:0]     addend,
    output logic [2*BITSIZE-1:0]   product,
    output logic                   done,
    output logic                   idle
);

    localparam int CNT_W = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        POSTCALC = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [2*BITSIZE-1:0]   acc_r;
    logic [2*BITSIZE-1:0]   mcand_r;
    logic [BITSIZE-1:0]     mreg_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   calc_last_s;
    logic                   skip_calc_s;

`ifdef EARLY_TERM_EN
    logic [BITSIZE-1:0]     mreg_shift_s;

    // Stop once no set multiplier bits remain; a zero operand skips CALC entirely.
    always_comb begin
        mreg_shift_s = mreg_r >> 1;
        calc_last_s  = (cnt_r == {CNT_W{1'b0}}) || (mreg_shift_s == {BITSIZE{1'b0}});
        skip_calc_s  = (multiplier == {BITSIZE{1'b0}}) || (multiplicand == {BITSIZE{1'b0}});
    end
`else
    // Fixed-length CALC: always walk all multiplier bits.
    always_comb begin
        calc_last_s = (cnt_r == {CNT_W{1'b0}});
        skip_calc_s = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (strt) begin
                    if (skip_calc_s) begin
                        state_s = POSTCALC;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (calc_last_s) begin
                    state_s = POSTCALC;
                end else begin
                    state_s = CALC;
                end
            end
            POSTCALC: state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // Datapath: operand capture, one partial-product bit per clock, result publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {(2*BITSIZE){1'b0}};
            mcand_r <= {(2*BITSIZE){1'b0}};
            mreg_r  <= {BITSIZE{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            product <= {(2*BITSIZE){1'b0}};
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (strt) begin
                        acc_r   <= {{BITSIZE{1'b0}}, addend};
                        mcand_r <= {{BITSIZE{1'b0}}, multiplicand};
                        mreg_r  <= multiplier;
                        cnt_r   <= CNT_W'(BITSIZE - 1);
                    end
                end
                CALC: begin
                    if (mreg_r[0]) begin
                        acc_r <= acc_r + mcand_r;
                    end
                    mcand_r <= mcand_r << 1;
                    mreg_r  <= mreg_r >> 1;
                    cnt_r   <= cnt_r - CNT_W'(1);
                end
                POSTCALC: begin
                    product <= acc_r;
                    done    <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    // Ready flag decoded straight from the state register.
    assign idle = (state_r == IDLE);

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: scoreboard queue of expected products,
// checked with immediate assertions when done pulses.
module tb_multiplier_seq;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           strt;
    logic [N-1:0]   a, b, c;
    logic [2*N-1:0] product;
    logic           done;
    logic           idle;

    int             tests = 0;
    int             fails = 0;
    int             cyc   = 0;
    int             e0_cyc;
    int             exp_latency;
    logic [2*N-1:0] sb_q[$];
    logic [2*N-1:0] last_exp;

    multiplier_seq #(.BITSIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .strt         (strt),
        .multiplicand (a),
        .multiplier   (b),
        .addend       (c),
        .product      (product),
        .done         (done),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_for(input logic [N-1:0] aa, input logic [N-1:0] bb);
`ifdef EARLY_TERM_EN
        int k = 0;
        if (aa == 16'd0 || bb == 16'd0) return 1;
        for (int i = 0; i < N; i++) if (bb[i]) k = i;
        return k + 2;
`else
        return N + 1;
`endif
    endfunction

    // Called at a negedge with idle=1; returns at the negedge after E0.
    task automatic start_op(input logic [N-1:0] aa, input logic [N-1:0] bb, input logic [N-1:0] cc);
        a    = aa;
        b    = bb;
        c    = cc;
        strt = 1'b1;
        sb_q.push_back(32'(aa) * 32'(bb) + 32'(cc));
        exp_latency = lat_for(aa, bb);
        @(negedge clk);
        strt   = 1'b0;
        e0_cyc = cyc;
        a      = 16'($urandom);
        b      = 16'($urandom);
        c      = 16'($urandom);
    endtask

    // Waits (bounded) at negedges for done; returns at the negedge where done=1.
    task automatic wait_done(input string tag, input bit check_lat);
        int budget = 100;
        logic [2*N-1:0] e;
        while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        if (done) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                last_exp = e;
                check({tag, "_product"}, product, e);
            end else begin
                check({tag, "_sb_nonempty"}, 1'b0, 1'b1);
            end
            if (check_lat) check({tag, "_latency"}, cyc - e0_cyc, exp_latency);
            check({tag, "_idle_at_done"}, idle, 1'b1);
        end
    endtask

    initial begin
        bit any_done;
        rst  = 1'b1;
        strt = 1'b0;
        a    = 16'd0;
        b    = 16'd0;
        c    = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_product", product, 32'd0);
        check("reset_done", done, 1'b0);
        check("reset_idle", idle, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Basic op plus single-pulse and hold checks.
        start_op(16'd123, 16'd456, 16'd7);
        check("busy_idle_low", idle, 1'b0);
        wait_done("basic", 1'b1);
        @(negedge clk);
        check("basic_done_pulse", done, 1'b0);
        repeat (10) @(negedge clk);
        check("basic_hold", product, 32'd56095);

        start_op(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("max", 1'b1);
        check("max_value", product, 32'hFFFF0000);

        // Back-to-back: start in the same cycle done is high.
        start_op(16'd142, 16'd7, 16'd6);
        wait_done("divrt", 1'b1);
        check("divrt_value", product, 32'd1000);
        start_op(16'd9, 16'd0, 16'd5);
        wait_done("zero_b", 1'b1);
        start_op(16'h1234, 16'd1, 16'd0);
        wait_done("b_one", 1'b1);
        start_op(16'd0, 16'd77, 16'd3);
        wait_done("zero_a", 1'b1);
        start_op(16'd5, 16'h8001, 16'd0);
        wait_done("b_msb", 1'b1);

        for (int i = 0; i < 4; i++) begin
            start_op(16'($urandom), 16'($urandom), 16'($urandom));
            wait_done("rand", 1'b1);
        end

        // strt while busy is ignored.
        @(negedge clk);
        start_op(16'd123, 16'd456, 16'd7);
        repeat (3) @(negedge clk);
        a = 16'd1; b = 16'd1; c = 16'd1; strt = 1'b1;
        repeat (2) @(negedge clk);
        strt = 1'b0;
        wait_done("busy_strt", 1'b0);
        check("busy_strt_value", product, 32'd56095);
        repeat (25) @(negedge clk);
        check("no_queued_op", product, 32'd56095);

        // Reset mid-CALC discards the op.
        start_op(16'd1000, 16'd1000, 16'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_idle", idle, 1'b1);
        check("midrst_product", product, 32'd0);
        check("midrst_done", done, 1'b0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("midrst_no_done", any_done, 1'b0);
        check("midrst_hold0", product, 32'd0);

        start_op(16'd3, 16'd5, 16'd1);
        wait_done("after_rst", 1'b1);
        check("after_rst_value", product, 32'd16);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
